// File: rtl/iob_axis_pkg.sv
// Shared definitions for the iob AXI-stream blocks (stream-in, stream-out,
// byte packer).
//   pack_state_e : packer FSM encoding (FILL, HOLD)
//   keep_mask(k) : lane mask with the k lowest bits set. Callers cast the
//                  result down to their own lane count.
package iob_axis_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } pack_state_e;

  // Widest lane count the mask helper supports (1024-bit words).
  localparam int unsigned KEEP_MAX = 128;

  function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned k);
    keep_mask = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      if (i < k) keep_mask[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/iob_axis_reg_slice.sv
// Single-entry AXI-stream holding register.
// Accepts a new entry whenever it is empty or its current entry drains in the
// same cycle, so back-to-back transfers run at full rate. Payload is held
// stable while m_valid_o=1 and m_ready_i=0.
// Ports:
//   clk, rst_n             : clock, async active-low reset (clears payload too)
//   s_data_i/s_valid_i/s_ready_o : upstream side
//   m_data_o/m_valid_o/m_ready_i : downstream side
module iob_axis_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] s_data_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  output logic [W-1:0] m_data_o,
  output logic         m_valid_o,
  input  logic         m_ready_i
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  assign s_ready_o = ~valid_q | m_ready_i;
  assign load      = s_valid_i & s_ready_o;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = s_data_i;
    end else if (m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign m_data_o  = data_q;
  assign m_valid_o = valid_q;

endmodule

// File: rtl/iob_axis_byte_packer.sv
// Packs a byte-wide AXI-stream into DATA_W-bit words with tkeep/tlast.
// A frame ending mid-word is flushed as a partial word with unused lanes
// zeroed. The completing byte goes straight into the output register on the
// edge that accepts it when that register is free; otherwise the word waits
// in the accumulator (HOLD) and input is stalled until the sink drains.
//
//   state | meaning
//   FILL  | collecting bytes, s_tready=1
//   HOLD  | complete word waiting for output register, s_tready=0
//
// Build option: define IOB_AXIS_BYTE_PACKER_BIG_ENDIAN_EN to place byte 0 in
// the MSB lane (partial words MSB-aligned, tkeep set from the MSB down).
// Default is little-endian (byte 0 in bits [7:0]).
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   s_tdata/s_tvalid/s_tready/s_tlast : byte input stream
//   m_tdata/m_tkeep/m_tvalid/m_tready/m_tlast : packed word output stream
//   frame_cnt                   : completed frames (m_tlast handshakes), wraps
module iob_axis_byte_packer
  import iob_axis_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NBYTES = DATA_W / 8,
  localparam int CNT_W  = $clog2(NBYTES) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  output logic [DATA_W-1:0] m_tdata,
  output logic [NBYTES-1:0] m_tkeep,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic [15:0]       frame_cnt
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NBYTES);
  localparam int               SLICE_W  = DATA_W + NBYTES + 1;

  pack_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] acc_q, acc_d, acc_nxt;
  logic              last_q, last_d;
  logic              ready_en_q;
  logic [15:0]       frame_cnt_q;

  logic              accept;
  logic              complete;
  logic              out_free;
  logic [CNT_W-1:0]  k_out;
  logic [NBYTES-1:0] keep_lo;
  logic [NBYTES-1:0] keep_out;
  logic [DATA_W-1:0] data_out;
  logic              last_out;
  logic              slice_valid;
  logic [SLICE_W-1:0] slice_in;
  logic [SLICE_W-1:0] slice_out;

  // Held low through reset and for the first cycle after release.
  assign s_tready = ready_en_q & (state_q == ST_FILL);
  assign accept   = s_tvalid & s_tready;

  always_comb begin
    cnt_inc = cnt_q + CNT_W'(1);
    acc_nxt = acc_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (cnt_q == CNT_W'(i)) begin
`ifdef IOB_AXIS_BYTE_PACKER_BIG_ENDIAN_EN
        acc_nxt[DATA_W-8-8*i +: 8] = s_tdata;
`else
        acc_nxt[8*i +: 8] = s_tdata;
`endif
      end
    end
    complete = accept & ((cnt_inc == FULL_CNT) | s_tlast);
  end

  // Word presented to the output register: the frozen accumulator in HOLD,
  // or the accumulator merged with the completing byte in FILL.
  always_comb begin
    if (state_q == ST_HOLD) begin
      k_out       = cnt_q;
      data_out    = acc_q;
      last_out    = last_q;
      slice_valid = 1'b1;
    end else begin
      k_out       = cnt_inc;
      data_out    = acc_nxt;
      last_out    = s_tlast;
      slice_valid = complete;
    end
    keep_lo = NBYTES'(keep_mask(32'(k_out)));
`ifdef IOB_AXIS_BYTE_PACKER_BIG_ENDIAN_EN
    keep_out = '0;
    for (int i = 0; i < NBYTES; i++) begin
      keep_out[NBYTES-1-i] = keep_lo[i];
    end
`else
    keep_out = keep_lo;
`endif
    slice_in = {last_out, keep_out, data_out};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    last_d  = last_q;
    unique case (state_q)
      ST_FILL: begin
        if (complete) begin
          if (out_free) begin
            cnt_d = '0;
            acc_d = '0;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = cnt_inc;
            acc_d   = acc_nxt;
            last_d  = s_tlast;
          end
        end else if (accept) begin
          cnt_d = cnt_inc;
          acc_d = acc_nxt;
        end
      end
      ST_HOLD: begin
        if (out_free) begin
          state_d = ST_FILL;
          cnt_d   = '0;
          acc_d   = '0;
          last_d  = 1'b0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      cnt_q      <= '0;
      acc_q      <= '0;
      last_q     <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      last_q     <= last_d;
      ready_en_q <= 1'b1;
    end
  end

  iob_axis_reg_slice #(
    .W (SLICE_W)
  ) u_out_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (slice_in),
    .s_valid_i (slice_valid),
    .s_ready_o (out_free),
    .m_data_o  (slice_out),
    .m_valid_o (m_tvalid),
    .m_ready_i (m_tready)
  );

  assign m_tdata = slice_out[DATA_W-1:0];
  assign m_tkeep = slice_out[DATA_W +: NBYTES];
  assign m_tlast = slice_out[SLICE_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (m_tvalid & m_tready & m_tlast) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_iob_axis_byte_packer.sv
module tb_iob_axis_byte_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [15:0] frame_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } word_t;

  word_t q[$];
  int    stall_cnt = 0;

  iob_axis_byte_packer #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && m_tvalid && m_tready) q.push_back({m_tlast, m_tkeep, m_tdata});
    if (rst_n && s_tvalid && !s_tready) stall_cnt <= stall_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, fails=%0d", fails);
    $fatal(1, "watchdog");
  end

  // Expected word for bytes in stream order; unused bytes passed as zero.
  function automatic logic [31:0] w4(input logic [7:0] b0, b1, b2, b3);
`ifdef IOB_AXIS_BYTE_PACKER_BIG_ENDIAN_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  function automatic logic [3:0] kp(input int k);
    logic [7:0] m;
    m = 8'((1 << k) - 1);
`ifdef IOB_AXIS_BYTE_PACKER_BIG_ENDIAN_EN
    m = m << (4 - k);
`endif
    return m[3:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (s_tready) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    tests++;
    fails++;
    $display("FAIL send_timeout: byte %h not accepted, s_tready=%b required 1", d, s_tready);
  endtask

  task automatic idle_in();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0; m_tready = 1'b0;
    tick(3);
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %b required 0", m_tvalid); end
    tests++; if (m_tdata !== 32'h0) begin fails++; $display("FAIL rst_tdata: got %h required 0", m_tdata); end
    tests++; if (m_tkeep !== 4'h0) begin fails++; $display("FAIL rst_tkeep: got %h required 0", m_tkeep); end
    tests++; if (m_tlast !== 1'b0) begin fails++; $display("FAIL rst_tlast: got %b required 0", m_tlast); end
    tests++; if (frame_cnt !== 16'h0) begin fails++; $display("FAIL rst_frame_cnt: got %h required 0", frame_cnt); end
    rst_n = 1'b1;
    tick(1);
    tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL rst_tready: got %b required 1", s_tready); end
    tick(1);
  endtask

  task automatic test_full_frame();
    int base, stall0;
    m_tready = 1'b1;
    base = q.size();
    stall0 = stall_cnt;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
    idle_in();
    tick(3);
    tests++;
    if (q.size() - base !== 2) begin
      fails++; $display("FAIL full_count: got %0d words required 2", q.size() - base);
    end else begin
      tests++;
      if (q[base] !== {1'b0, kp(4), w4(8'h01, 8'h02, 8'h03, 8'h04)}) begin
        fails++; $display("FAIL full_word0: got %h required %h", q[base], {1'b0, kp(4), w4(8'h01, 8'h02, 8'h03, 8'h04)});
      end
      tests++;
      if (q[base+1] !== {1'b1, kp(4), w4(8'h05, 8'h06, 8'h07, 8'h08)}) begin
        fails++; $display("FAIL full_word1: got %h required %h", q[base+1], {1'b1, kp(4), w4(8'h05, 8'h06, 8'h07, 8'h08)});
      end
    end
    tests++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL full_frame_cnt: got %0d required 1", frame_cnt); end
    tests++; if (stall_cnt - stall0 !== 0) begin fails++; $display("FAIL full_no_stall: got %0d stall cycles required 0", stall_cnt - stall0); end
  endtask

  task automatic test_short_frame();
    int base;
    m_tready = 1'b1;
    base = q.size();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    idle_in();
    tick(3);
    tests++;
    if (q.size() - base !== 2) begin
      fails++; $display("FAIL short_count: got %0d words required 2", q.size() - base);
    end else begin
      tests++;
      if (q[base] !== {1'b1, kp(3), w4(8'hAA, 8'hBB, 8'hCC, 8'h00)}) begin
        fails++; $display("FAIL short_word3: got %h required %h", q[base], {1'b1, kp(3), w4(8'hAA, 8'hBB, 8'hCC, 8'h00)});
      end
      tests++;
      if (q[base+1] !== {1'b1, kp(2), w4(8'h11, 8'h22, 8'h00, 8'h00)}) begin
        fails++; $display("FAIL short_word2: got %h required %h", q[base+1], {1'b1, kp(2), w4(8'h11, 8'h22, 8'h00, 8'h00)});
      end
    end
    tests++; if (frame_cnt !== 16'd3) begin fails++; $display("FAIL short_frame_cnt: got %0d required 3", frame_cnt); end
  endtask

  task automatic test_backpressure();
    int base;
    logic [36:0] w0, w1;
    w0 = {1'b0, kp(4), w4(8'h11, 8'h12, 8'h13, 8'h14)};
    w1 = {1'b1, kp(4), w4(8'h15, 8'h16, 8'h17, 8'h18)};
    m_tready = 1'b0;
    base = q.size();
    for (int i = 0; i < 4; i++) send_byte(8'(8'h11 + i), 1'b0);
    tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL bp_latency: m_tvalid got %b required 1", m_tvalid); end
    tests++; if ({m_tlast, m_tkeep, m_tdata} !== w0) begin fails++; $display("FAIL bp_first: got %h required %h", {m_tlast, m_tkeep, m_tdata}, w0); end
    for (int i = 4; i < 8; i++) send_byte(8'(8'h11 + i), i == 7);
    idle_in();
    tick(3);
    tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL bp_hold_ready: got %b required 0", s_tready); end
    tests++; if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== {1'b1, w0}) begin fails++; $display("FAIL bp_stable: got %h required %h", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, w0}); end
    tests++; if (q.size() - base !== 0) begin fails++; $display("FAIL bp_no_xfer: got %0d words required 0", q.size() - base); end
    m_tready = 1'b1;
    tick(1);
    tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b required 1", s_tready); end
    tick(3);
    tests++;
    if (q.size() - base !== 2) begin
      fails++; $display("FAIL bp_count: got %0d words required 2", q.size() - base);
    end else begin
      tests++; if (q[base] !== w0) begin fails++; $display("FAIL bp_word0: got %h required %h", q[base], w0); end
      tests++; if (q[base+1] !== w1) begin fails++; $display("FAIL bp_word1: got %h required %h", q[base+1], w1); end
    end
    tests++; if (frame_cnt !== 16'd4) begin fails++; $display("FAIL bp_frame_cnt: got %0d required 4", frame_cnt); end
  endtask

  task automatic test_mid_reset();
    int base;
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'(8'h21 + i), 1'b0);
    idle_in();
    rst_n = 1'b0;
    #1;
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL midrst_tvalid: got %b required 0", m_tvalid); end
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL midrst_frame_cnt: got %0d required 0", frame_cnt); end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    base = q.size();
    m_tready = 1'b1;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h06, 1'b1);
    idle_in();
    tick(3);
    tests++;
    if (q.size() - base !== 2) begin
      fails++; $display("FAIL midrst_count: got %0d words required 2", q.size() - base);
    end else begin
      tests++;
      if (q[base] !== {1'b1, kp(2), w4(8'h01, 8'h02, 8'h00, 8'h00)}) begin
        fails++; $display("FAIL midrst_word0: got %h required %h", q[base], {1'b1, kp(2), w4(8'h01, 8'h02, 8'h00, 8'h00)});
      end
      tests++;
      if (q[base+1] !== {1'b1, kp(4), w4(8'h03, 8'h04, 8'h05, 8'h06)}) begin
        fails++; $display("FAIL midrst_word1: got %h required %h", q[base+1], {1'b1, kp(4), w4(8'h03, 8'h04, 8'h05, 8'h06)});
      end
    end
    tests++; if (frame_cnt !== 16'd2) begin fails++; $display("FAIL midrst_frame_cnt2: got %0d required 2", frame_cnt); end
  endtask

  task automatic test_frame_cnt_wrap();
    int base, bad;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    m_tready = 1'b1;
    base = q.size();
    for (int i = 0; i < 65535; i++) send_byte(8'(i), 1'b1);
    idle_in();
    tick(3);
    tests++; if (frame_cnt !== 16'hFFFF) begin fails++; $display("FAIL wrap_pre: got %h required ffff", frame_cnt); end
    send_byte(8'h5A, 1'b1);
    idle_in();
    tick(3);
    tests++; if (frame_cnt !== 16'h0000) begin fails++; $display("FAIL wrap_zero: got %h required 0000", frame_cnt); end
    tests++;
    if (q.size() - base !== 65536) begin
      fails++; $display("FAIL wrap_count: got %0d words required 65536", q.size() - base);
    end else begin
      bad = 0;
      for (int i = 0; i < 65536; i++) begin
        if (q[base+i] !== {1'b1, kp(1), w4((i == 65535) ? 8'h5A : 8'(i), 8'h00, 8'h00, 8'h00)}) bad++;
      end
      tests++; if (bad !== 0) begin fails++; $display("FAIL wrap_words: got %0d bad single-byte words required 0", bad); end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_backpressure();
    test_mid_reset();
    test_frame_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
